// File: rtl/alu_pipe.sv
// alu_pipe - two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Stage 1 registers the (optionally inverted) operands and control; stage 2
// computes the result and flags from those registers and holds them until the
// consumer takes them. The pipeline can hold one op per stage, and in_ready is
// combinational, so a full pipeline keeps accepting while the output drains.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; op accepted when both are high
//   a, b, cin             operands and adder carry-in
//   op                    000 rotl, 001 shl, 010 rotr, 011 shr, 100 add,
//                         101 or, 110 xor, 111 and
//   inv_a, inv_b          invert operand before use
//   sign                  1 = signed overflow rule, 0 = unsigned (ofl = cout)
//   tag                   opaque tag returned with the result
//   out_valid / out_ready output handshake; result consumed when both are high
//   result, cout, ofl, z  result and flags
//   out_tag               tag of the presented result
//   clr_sticky            clear the sticky overflow flag
//   ofl_sticky            set by any consumed result with ofl = 1

module alu_pipe #(
    parameter int WIDTH     = 16,
    parameter int TAG_W     = 4,
    parameter int STICKY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             sign,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ofl,
    output logic             z,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_sticky,
    output logic             ofl_sticky
);

    localparam int SHW = $clog2(WIDTH);

    // stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] a1_q, b1_q;
    logic             cin1_q, sign1_q;
    logic [2:0]       op1_q;
    logic [TAG_W-1:0] tag1_q;

    // stage 2 registers
    logic             s2_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q, ofl_q, z_q;
    logic [TAG_W-1:0] tag2_q;

    // stage 2 next values
    logic [WIDTH-1:0]   res_d;
    logic               cout_d, ofl_d;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rotl_w, rotr_w;
    logic [WIDTH:0]     sum_w;

    logic s2_adv, accept;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    // Rotates are done on a doubled copy of the operand so the wrapped bits
    // fall out of a single plain shift.
    always_comb begin
        shamt  = b1_q[SHW-1:0];
        rotl_w = {a1_q, a1_q} << shamt;
        rotr_w = {a1_q, a1_q} >> shamt;
        sum_w  = {1'b0, a1_q} + {1'b0, b1_q} + {{WIDTH{1'b0}}, cin1_q};
        res_d  = '0;
        cout_d = 1'b0;
        ofl_d  = 1'b0;
        case (op1_q)
            3'b000: res_d = rotl_w[2*WIDTH-1:WIDTH];
            3'b001: res_d = a1_q << shamt;
            3'b010: res_d = rotr_w[WIDTH-1:0];
            3'b011: res_d = a1_q >> shamt;
            3'b100: begin
                res_d  = sum_w[WIDTH-1:0];
                cout_d = sum_w[WIDTH];
                if (sign1_q)
                    ofl_d = (a1_q[WIDTH-1] == b1_q[WIDTH-1]) &&
                            (sum_w[WIDTH-1] != a1_q[WIDTH-1]);
                else
                    ofl_d = sum_w[WIDTH];
            end
            3'b101: res_d = a1_q | b1_q;
            3'b110: res_d = a1_q ^ b1_q;
            3'b111: res_d = a1_q & b1_q;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            cin1_q     <= 1'b0;
            sign1_q    <= 1'b0;
            op1_q      <= 3'b000;
            tag1_q     <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            ofl_q      <= 1'b0;
            z_q        <= 1'b0;
            tag2_q     <= '0;
        end else begin
            if (in_ready)
                s1_valid_q <= in_valid;
            if (accept) begin
                a1_q    <= inv_a ? ~a : a;
                b1_q    <= inv_b ? ~b : b;
                cin1_q  <= cin;
                sign1_q <= sign;
                op1_q   <= op;
                tag1_q  <= tag;
            end
            if (s2_adv)
                s2_valid_q <= s1_valid_q;
            // Only load on a real op so a bubble never disturbs held outputs.
            if (s2_adv && s1_valid_q) begin
                res_q  <= res_d;
                cout_q <= cout_d;
                ofl_q  <= ofl_d;
                z_q    <= (res_d == '0);
                tag2_q <= tag1_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign cout      = cout_q;
    assign ofl       = ofl_q;
    assign z         = z_q;
    assign out_tag   = tag2_q;

    generate
        if (STICKY_EN != 0) begin : g_sticky
            logic sticky_q, sticky_d;
            // A consumed overflow wins over a simultaneous clear.
            always_comb begin
                sticky_d = sticky_q;
                if (clr_sticky)
                    sticky_d = 1'b0;
                if (s2_valid_q && out_ready && ofl_q)
                    sticky_d = 1'b1;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sticky_q <= 1'b0;
                else
                    sticky_q <= sticky_d;
            end
            assign ofl_sticky = sticky_q;
        end else begin : g_no_sticky
            assign ofl_sticky = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, inv_a = 1'b0, inv_b = 1'b0, sign = 1'b0;
    logic [2:0]  op = '0;
    logic [3:0]  tag = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] result;
    logic        cout, ofl, z;
    logic [3:0]  out_tag;
    logic        clr_sticky = 1'b0, ofl_sticky;

    logic        in_valid32 = 1'b0, in_ready32;
    logic [31:0] a32 = '0, b32 = '0, result32;
    logic [2:0]  op32 = '0;
    logic        out_valid32, cout32, ofl32, z32, ofl_sticky32;
    logic [3:0]  out_tag32;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .TAG_W(4), .STICKY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .inv_a(inv_a), .inv_b(inv_b),
        .sign(sign), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ofl(ofl), .z(z), .out_tag(out_tag),
        .clr_sticky(clr_sticky), .ofl_sticky(ofl_sticky)
    );

    alu_pipe #(.WIDTH(32), .TAG_W(4), .STICKY_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(1'b0), .op(op32), .inv_a(1'b0), .inv_b(1'b0),
        .sign(1'b0), .tag(4'h0), .out_valid(out_valid32), .out_ready(1'b1),
        .result(result32), .cout(cout32), .ofl(ofl32), .z(z32), .out_tag(out_tag32),
        .clr_sticky(1'b0), .ofl_sticky(ofl_sticky32)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: bit-by-bit rotates and integer arithmetic.
    function automatic exp_t model(logic [15:0] ai, logic [15:0] bi, logic ci, logic [2:0] o,
                                   logic ia, logic ib, logic sg, logic [3:0] t);
        exp_t e;
        logic [15:0] aa, bb;
        int sh, s;
        aa = ia ? ~ai : ai;
        bb = ib ? ~bi : bi;
        sh = int'(bb[3:0]);
        e.res = '0; e.co = 1'b0; e.ov = 1'b0; e.tag = t;
        case (o)
            3'd0: for (int i = 0; i < 16; i++) e.res[(i + sh) % 16] = aa[i];
            3'd1: e.res = aa << sh;
            3'd2: for (int i = 0; i < 16; i++) e.res[i] = aa[(i + sh) % 16];
            3'd3: e.res = aa >> sh;
            3'd4: begin
                s = int'(aa) + int'(bb) + int'(ci);
                e.res = s[15:0];
                e.co  = s[16];
                e.ov  = sg ? ((aa[15] == bb[15]) && (e.res[15] != aa[15])) : e.co;
            end
            3'd5: e.res = aa | bb;
            3'd6: e.res = aa ^ bb;
            default: e.res = aa & bb;
        endcase
        e.z = (e.res == 16'h0);
        return e;
    endfunction

    // Scoreboard: push on the cycle an accept will happen, pop on output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("cout", cout, e.co);
                chk("ofl", ofl, e.ov);
                chk("z", z, e.z);
                chk("out_tag", out_tag, e.tag);
            end
            delivered++;
        end
        if (rst_n && in_valid && in_ready)
            sb.push_back(model(a, b, cin, op, inv_a, inv_b, sign, tag));
    end

    task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        input logic [2:0] o, input logic ia, input logic ib,
                        input logic sg, input logic [3:0] t);
        logic rdy;
        int n;
        a = ai; b = bi; cin = ci; op = o; inv_a = ia; inv_b = ib; sign = sg; tag = t;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic run32(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] exp);
        int n;
        a32 = ai; b32 = bi; op32 = 3'd0; in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        n = 0;
        while (!out_valid32 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w32_rotl", result32, exp);
    endtask

    initial begin
        logic [15:0] held_res;
        logic [3:0]  held_tag;
        logic        saw_not_ready;
        int          d0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_sticky", ofl_sticky, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed vectors
        send(16'h7FFF, 16'h0001, 0, 3'd4, 0, 0, 1, 4'd1);
        wait_out(10);
        @(posedge clk);
        #1;
        chk("sticky_after_ofl", ofl_sticky, 1);
        send(16'hFFFF, 16'h0001, 0, 3'd4, 0, 0, 0, 4'd2);
        send(16'hFFFF, 16'h0001, 1, 3'd4, 0, 1, 0, 4'd3);
        send(16'h8001, 16'h0001, 0, 3'd0, 0, 0, 0, 4'd4);
        send(16'h8001, 16'h0001, 0, 3'd2, 0, 0, 0, 4'd5);
        send(16'h8001, 16'h0004, 0, 3'd3, 0, 0, 0, 4'd6);
        send(16'h8001, 16'h0000, 0, 3'd1, 0, 0, 0, 4'd7);
        send(16'h8001, 16'h0010, 0, 3'd0, 0, 0, 0, 4'd8);
        for (int i = 0; i < 30; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 4'(i));
        drain();

        // backpressure: 6 ops streamed, out_ready low for 3 cycles mid-stream
        d0 = delivered;
        saw_not_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'(16'h1000 + i), 16'(i), 0, 3'd4, 0, 0, 0, 4'(i));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held_res = result;
                held_tag = out_tag;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (!in_ready) saw_not_ready = 1'b1;
                    chk("stall_result_stable", result, held_res);
                    chk("stall_tag_stable", out_tag, held_tag);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", saw_not_ready, 1);
        chk("bp_delivered_count", delivered - d0, 6);

        // sticky: stalled overflow does not set; consumed + clear sets; clear alone clears
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("sticky_cleared", ofl_sticky, 0);
        out_ready = 1'b0;
        send(16'hFFFF, 16'h0002, 0, 3'd4, 0, 0, 0, 4'd9);
        wait_out(10);
        repeat (3) @(posedge clk);
        #1;
        chk("sticky_stalled", ofl_sticky, 0);
        clr_sticky = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("sticky_set_wins", ofl_sticky, 1);
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("sticky_clr_alone", ofl_sticky, 0);

        // reset with both stages full
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 0, 3'd4, 0, 0, 0, 4'd10);
        send(16'h0002, 16'h0002, 0, 3'd4, 0, 0, 0, 4'd11);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0003; b = 16'h0004; cin = 0; op = 3'd4; inv_a = 0; inv_b = 0; sign = 0; tag = 4'd12;
        in_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2_out_valid", out_valid, 1);
        drain();

        // WIDTH=32 rotates
        run32(32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
        run32(32'h8000_0000, 32'h0000_001F, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
